// File: rtl/segment_frame_collect.sv
// Collects SEG_COUNT segment words into one frame and reports the frame's sum and maximum.
// A finished frame is held until downstream takes it; the handoff cycle can already accept the next frame's first word.
module segment_frame_collect #(
   parameter int WIDTH     = 32,
   parameter int SEG_COUNT = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             seg_valid,
   input  logic [WIDTH-1:0] seg_data,
   output logic             seg_ready,
   output logic             frame_valid,
   input  logic             frame_ready,
   output logic [WIDTH+7:0] frame_sum,
   output logic [WIDTH-1:0] frame_max,
   output logic [7:0]       frame_id
);

   localparam int CW = (SEG_COUNT > 1) ? $clog2(SEG_COUNT) : 1;
   localparam logic [CW-1:0] LAST = CW'(SEG_COUNT - 1);

   typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

   function automatic logic [WIDTH-1:0] umax(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      return (b > a) ? b : a;
   endfunction

   state_t           state, state_nxt;
   logic [CW-1:0]    seg_cnt, seg_cnt_nxt;
   logic [WIDTH+7:0] acc_sum, acc_sum_nxt, frame_sum_nxt, sum_add;
   logic [WIDTH-1:0] acc_max, acc_max_nxt, frame_max_nxt, max_add;
   logic [7:0]       frame_id_nxt;
   logic             accept;

   // In HOLD the collector only takes a word on the handoff cycle, so ready follows frame_ready.
   assign seg_ready   = reset & ((state == COLLECT) | frame_ready);
   assign frame_valid = (state == HOLD);
   assign accept      = seg_valid & seg_ready;
   assign sum_add     = acc_sum + {8'd0, seg_data};
   assign max_add     = umax(acc_max, seg_data);

   // Next-state and next-accumulator logic.
   always_comb begin
      state_nxt     = state;
      seg_cnt_nxt   = seg_cnt;
      acc_sum_nxt   = acc_sum;
      acc_max_nxt   = acc_max;
      frame_sum_nxt = frame_sum;
      frame_max_nxt = frame_max;
      frame_id_nxt  = frame_id;
      case (state)
         COLLECT: begin
            if (accept && (seg_cnt == LAST)) begin
               state_nxt     = HOLD;
               frame_sum_nxt = sum_add;
               frame_max_nxt = max_add;
               seg_cnt_nxt   = '0;
               acc_sum_nxt   = '0;
               acc_max_nxt   = '0;
            end else if (accept) begin
               acc_sum_nxt = sum_add;
               acc_max_nxt = max_add;
               seg_cnt_nxt = seg_cnt + CW'(1);
            end else begin
               state_nxt = COLLECT;
            end
         end
         HOLD: begin
            if (frame_ready) begin
               state_nxt    = COLLECT;
               frame_id_nxt = frame_id + 8'd1;
               // A word offered during handoff becomes word 0 of the next frame.
               if (seg_valid) begin
                  acc_sum_nxt = {8'd0, seg_data};
                  acc_max_nxt = seg_data;
                  seg_cnt_nxt = CW'(1);
               end else begin
                  acc_sum_nxt = '0;
                  acc_max_nxt = '0;
                  seg_cnt_nxt = '0;
               end
            end else begin
               state_nxt = HOLD;
            end
         end
         default: begin
            state_nxt = COLLECT;
         end
      endcase
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= COLLECT;
         seg_cnt   <= '0;
         acc_sum   <= '0;
         acc_max   <= '0;
         frame_sum <= '0;
         frame_max <= '0;
         frame_id  <= 8'd0;
      end else begin
         state     <= state_nxt;
         seg_cnt   <= seg_cnt_nxt;
         acc_sum   <= acc_sum_nxt;
         acc_max   <= acc_max_nxt;
         frame_sum <= frame_sum_nxt;
         frame_max <= frame_max_nxt;
         frame_id  <= frame_id_nxt;
      end
   end

endmodule

// File: tb/tb_segment_frame_collect.sv
// Randomized bench for segment_frame_collect against a frame-level reference model.
module tb_segment_frame_collect;

   localparam int W   = 32;
   localparam int SEG = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          seg_valid;
   logic [W-1:0]  seg_data;
   logic          seg_ready;
   logic          frame_valid;
   logic          frame_ready;
   logic [W+7:0]  frame_sum;
   logic [W-1:0]  frame_max;
   logic [7:0]    frame_id;

   int errors = 0;
   int checks = 0;

   // Reference model: words of the open frame, plus the pending finished frame.
   logic [W-1:0] m_words[$];
   bit           m_pending;
   logic [W+7:0] m_sum;
   logic [W-1:0] m_max;
   int           m_id;

   segment_frame_collect #(.WIDTH(W), .SEG_COUNT(SEG)) dut (
      .clk(clk), .reset(reset), .seg_valid(seg_valid), .seg_data(seg_data),
      .seg_ready(seg_ready), .frame_valid(frame_valid), .frame_ready(frame_ready),
      .frame_sum(frame_sum), .frame_max(frame_max), .frame_id(frame_id)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_words.delete();
      m_pending = 1'b0;
      m_sum = '0;
      m_max = '0;
      m_id = 0;
   endtask

   // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
   task automatic step(input bit v, input logic [W-1:0] d, input bit fr);
      bit acc;
      longint s;
      logic [W-1:0] mx;
      seg_valid = v; seg_data = d; frame_ready = fr;
      @(posedge clk);
      acc = v && (!m_pending || fr);
      if (m_pending && fr) begin
         m_pending = 1'b0;
         m_id = (m_id + 1) % 256;
      end
      if (acc) begin
         m_words.push_back(d);
         if (m_words.size() == SEG) begin
            s = 0; mx = '0;
            foreach (m_words[i]) begin
               s += longint'(m_words[i]);
               if (m_words[i] > mx) mx = m_words[i];
            end
            m_sum = s[W+7:0];
            m_max = mx;
            m_pending = 1'b1;
            m_words.delete();
         end
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      seg_valid = 1'b0; seg_data = '0; frame_ready = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b0; seg_valid = 1'b1; seg_data = 32'h5; frame_ready = 1'b1;
      #1;
      checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL reset_seg_ready: got %b want 0", seg_ready); end
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL reset_frame_valid: got %b want 0", frame_valid); end
      checks++; if (frame_sum !== 40'd0) begin errors++; $display("FAIL reset_frame_sum: got %h want 0", frame_sum); end
      checks++; if (frame_max !== 32'd0) begin errors++; $display("FAIL reset_frame_max: got %h want 0", frame_max); end
      checks++; if (frame_id !== 8'd0) begin errors++; $display("FAIL reset_frame_id: got %0d want 0", frame_id); end
      @(negedge clk);
      @(negedge clk);
      do_reset();
   endtask

   task automatic test_basic();
      for (int i = 1; i <= SEG; i++) step(1'b1, W'(i), 1'b0);
      checks++; if (frame_valid !== 1'b1) begin errors++; $display("FAIL basic_valid: got %b want 1", frame_valid); end
      checks++; if (frame_sum !== 40'd36) begin errors++; $display("FAIL basic_sum: got %0d want 36", frame_sum); end
      checks++; if (frame_max !== 32'd8) begin errors++; $display("FAIL basic_max: got %0d want 8", frame_max); end
      checks++; if (frame_id !== 8'd0) begin errors++; $display("FAIL basic_id: got %0d want 0", frame_id); end
      checks++; if (seg_ready !== 1'b0) begin errors++; $display("FAIL basic_ready: got %b want 0", seg_ready); end
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 32'hAA, 1'b0);
         checks++; if (frame_valid !== 1'b1 || frame_sum !== 40'd36 || frame_max !== 32'd8 || frame_id !== 8'd0 || seg_ready !== 1'b0)
            begin errors++; $display("FAIL backpressure_hold: got v=%b sum=%0d max=%0d id=%0d rdy=%b want 1/36/8/0/0", frame_valid, frame_sum, frame_max, frame_id, seg_ready); end
      end
      frame_ready = 1'b1;
      #1;
      checks++; if (seg_ready !== 1'b1) begin errors++; $display("FAIL handoff_ready: got %b want 1", seg_ready); end
      step(1'b1, 32'hAA, 1'b1);
      checks++; if (frame_valid !== 1'b0 || frame_id !== 8'd1) begin errors++; $display("FAIL handoff: got v=%b id=%0d want 0/1", frame_valid, frame_id); end
      for (int i = 1; i < SEG; i++) step(1'b1, W'(i), 1'b0);
      checks++; if (frame_valid !== 1'b1 || frame_sum !== 40'd198 || frame_max !== 32'hAA)
         begin errors++; $display("FAIL b2b_frame: got v=%b sum=%0d max=%h want 1/198/aa", frame_valid, frame_sum, frame_max); end
      step(1'b0, '0, 1'b1);
      checks++; if (frame_valid !== 1'b0 || frame_id !== 8'd2) begin errors++; $display("FAIL b2b_handoff: got v=%b id=%0d want 0/2", frame_valid, frame_id); end
   endtask

   task automatic test_extremes();
      for (int i = 0; i < SEG; i++) step(1'b1, 32'hFFFF_FFFF, 1'b0);
      checks++; if (frame_sum !== 40'h7_FFFF_FFF8) begin errors++; $display("FAIL extreme_sum: got %h want 7fffffff8", frame_sum); end
      checks++; if (frame_max !== 32'hFFFF_FFFF) begin errors++; $display("FAIL extreme_max: got %h want ffffffff", frame_max); end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_gapped();
      int done = 0;
      int started = 0;
      int cyc = 0;
      bit prev;
      bit fr;
      do_reset();
      while (done < 3 && cyc < 2000) begin
         prev = m_pending;
         fr = ($urandom_range(0, 1) == 1);
         step($urandom_range(0, 1) == 1, $urandom, fr);
         cyc++;
         if (prev && fr) done++;
         checks++; if (frame_valid !== m_pending) begin errors++; $display("FAIL gapped_valid: got %b want %b", frame_valid, m_pending); end
         if (m_pending) begin
            checks++; if (frame_sum !== m_sum || frame_max !== m_max || frame_id !== 8'(m_id))
               begin errors++; $display("FAIL gapped_frame: got %h/%h/%0d want %h/%h/%0d", frame_sum, frame_max, frame_id, m_sum, m_max, m_id); end
            if (!prev) begin
               checks++; if (frame_id !== 8'(started)) begin errors++; $display("FAIL gapped_id_seq: got %0d want %0d", frame_id, started); end
               started++;
            end
         end
      end
      checks++; if (done != 3) begin errors++; $display("FAIL gapped_timeout: got %0d frames want 3", done); end
   endtask

   task automatic test_reset_midframe();
      for (int i = 0; i < 5; i++) step(1'b1, $urandom, 1'b0);
      #2 reset = 1'b0;
      #1;
      checks++; if (frame_valid !== 1'b0 || frame_sum !== 40'd0 || frame_max !== 32'd0 || frame_id !== 8'd0 || seg_ready !== 1'b0)
         begin errors++; $display("FAIL midreset_outputs: got v=%b sum=%h max=%h id=%0d rdy=%b want all 0", frame_valid, frame_sum, frame_max, frame_id, seg_ready); end
      @(negedge clk);
      reset = 1'b1;
      model_reset();
      for (int i = 0; i < SEG - 1; i++) step(1'b1, 32'd2, 1'b0);
      checks++; if (frame_valid !== 1'b0) begin errors++; $display("FAIL midreset_early: got %b want 0", frame_valid); end
      step(1'b1, 32'd2, 1'b0);
      checks++; if (frame_valid !== 1'b1 || frame_sum !== 40'd16 || frame_max !== 32'd2 || frame_id !== 8'd0)
         begin errors++; $display("FAIL midreset_frame: got v=%b sum=%0d max=%0d id=%0d want 1/16/2/0", frame_valid, frame_sum, frame_max, frame_id); end
      step(1'b0, '0, 1'b1);
   endtask

   task automatic test_wrap();
      int seen = 0;
      do_reset();
      for (int c = 0; c < 257 * SEG + 4 && seen < 257; c++) begin
         step(1'b1, $urandom, 1'b1);
         if (frame_valid) begin
            checks++; if (frame_id !== 8'(m_id) || frame_sum !== m_sum || frame_max !== m_max)
               begin errors++; $display("FAIL wrap_frame: got id=%0d sum=%h want id=%0d sum=%h", frame_id, frame_sum, m_id, m_sum); end
            if (seen == 255) begin
               checks++; if (frame_id !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d want 255", frame_id); end
            end
            if (seen == 256) begin
               checks++; if (frame_id !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d want 0", frame_id); end
            end
            seen++;
         end
      end
      checks++; if (seen != 257) begin errors++; $display("FAIL wrap_count: got %0d frames want 257", seen); end
   endtask

   initial begin
      model_reset();
      @(negedge clk);
      test_reset();
      test_basic();
      test_back_to_back();
      test_extremes();
      test_gapped();
      test_reset_midframe();
      test_wrap();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/segment_frame_collect.md
SEGMENT_FRAME_COLLECT -- requirements
Module: segment_frame_collect

Interface
REQ-001 Parameter WIDTH, default 32: width of each segment word; the segment words are the segment_N_combine outputs of the if/else segment stage.
REQ-002 Parameter SEG_COUNT, default 8: segments per frame; legal range 2..256.
REQ-003 Clock and reset: one clock, clk; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-low reset.
REQ-006 seg_valid  input  1  segment word present on seg_data.
REQ-007 seg_data  input  WIDTH  segment word (unsigned).
REQ-008 seg_ready  output  1  collector accepts seg_data this cycle.
REQ-009 frame_valid  output  1  completed frame on frame_* outputs.
REQ-010 frame_ready  input  1  downstream consumes the frame.
REQ-011 frame_sum  output  WIDTH+8  unsigned sum of the frame's SEG_COUNT words.
REQ-012 frame_max  output  WIDTH  largest word in the frame (unsigned compare).
REQ-013 frame_id  output  8  frame sequence number.

Function
REQ-014 Accept rule: a word is accepted on a rising edge where seg_valid=1 and seg_ready=1; no other edge changes the accumulators.
REQ-015 FSM states: COLLECT and HOLD.
REQ-016 COLLECT: seg_ready=1 and frame_valid=0; each accept adds seg_data to acc_sum, updates acc_max = max(acc_max, seg_data), and increments seg_cnt.
REQ-017 COLLECT to HOLD: on the accept with seg_cnt=SEG_COUNT-1, the next edge loads frame_sum/frame_max with the totals including that word, clears seg_cnt, and sets frame_valid=1 (latency 1 cycle after the last accept).
REQ-018 HOLD: frame_valid=1; frame_sum, frame_max and frame_id stay stable until handoff; seg_ready=frame_ready (combinational).
REQ-019 HOLD handoff: when frame_ready=1, the edge clears frame_valid, increments frame_id mod 256, and returns to COLLECT.
REQ-020 Back-to-back: if seg_valid=1 during the handoff cycle, that word is accepted as word 0 of the next frame: acc_sum=seg_data, acc_max=seg_data, seg_cnt=1.
REQ-021 Handoff without seg_valid: acc_sum=0, acc_max=0, seg_cnt=0.
REQ-022 HOLD with frame_ready=0: seg_ready=0, seg_valid is ignored, and no word is lost or double-counted.
REQ-023 Arithmetic: acc_sum is WIDTH+8 bits and never overflows for SEG_COUNT<=256; there is no saturation.
REQ-024 Max compare: on equal values, acc_max is unchanged (value-identical either way).
REQ-025 frame_id wrap: 255 to 0 with no flag.
REQ-026 seg_valid may drop mid-frame for any number of cycles; the partial accumulators hold.
REQ-027 No combinational path from seg_valid or seg_data to any output; the only combinational path is frame_ready to seg_ready.

Reset
REQ-028 When reset=0, the block asynchronously enters COLLECT with seg_cnt=0, acc_sum=0, acc_max=0, frame_sum=0, frame_max=0, frame_id=0, frame_valid=0.
REQ-029 While reset=0, seg_ready=0.
REQ-030 Reset deassertion is synchronized externally; the first accept can occur on the first edge with reset=1.
REQ-031 Reset asserted mid-frame or during HOLD discards the partial or pending frame; no frame_valid pulse follows.

Verification
REQ-032 Basic frame: SEG_COUNT=8, words 1..8 on consecutive cycles with frame_ready=0 -> one cycle after word 8: frame_valid=1, frame_sum=36, frame_max=8, frame_id=0, seg_ready=0.
REQ-033 Back-pressure: hold frame_ready=0 for 5 cycles with seg_valid=1 and seg_data=0xAA -> outputs stable and no accept; then frame_ready=1 for 1 cycle -> frame_id=1 and next frame starts with acc_sum=0xAA, seg_cnt=1.
REQ-034 Width extremes: 8 words of 0xFFFFFFFF -> frame_sum=0x7FFFFFFF8, frame_max=0xFFFFFFFF.
REQ-035 Gapped input: random seg_valid gaps (about 50% duty) over 3 frames of random data -> sums and maxima match the reference model and frame_id runs 0,1,2.
REQ-036 Reset mid-frame: assert reset after 5 words -> all outputs 0 immediately; then 8 words of 2 -> frame_sum=16 and frame_id=0.
REQ-037 Wrap: 257 frames with frame_ready=1 throughout -> frame_id sequence ...,254,255,0.
